// File: rtl/ncl_mult3_seq_arbiter.sv
// Clocked front end for a shared, unclocked 3x3 NCL multiplier. It arbitrates among
// NUM_REQ requesters, runs one DATA/NULL wavefront pair per request and returns the product.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where valid and ready
// are both 1. A requester holds req_valid and its operands stable until it sees req_ready.
// req_ready is combinational (IDLE only). The DUT holds rsp_* stable while rsp_valid=1
// until rsp_ready=1.
module ncl_mult3_seq_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [3*NUM_REQ-1:0]   req_a,
    input  logic [3*NUM_REQ-1:0]   req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2:0]             rsp_id,
    output logic [5:0]             rsp_prod,
    output logic [1:0]             rsp_err,
    output logic [2:0]             a_rail1,
    output logic [2:0]             a_rail0,
    output logic [2:0]             b_rail1,
    output logic [2:0]             b_rail0,
    output logic                   mult_ki,
    output logic                   mult_rst,
    input  logic [5:0]             p_rail1,
    input  logic [5:0]             p_rail0,
    input  logic                   mult_ko
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_RST_HOLD, S_IDLE, S_DRIVE, S_DATA_WAIT,
        S_NULLING, S_NULL_WAIT, S_RECOVER, S_RESP
    } state_t;

    state_t                          state_q, state_d;
    logic                            hold_q, hold_d;
    logic [2:0]                      ptr_q, ptr_d;
    logic [2:0]                      op_a_q, op_a_d, op_b_q, op_b_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [2:0]                      rsp_id_q, rsp_id_d;
    logic [5:0]                      rsp_prod_q, rsp_prod_d;
    logic [1:0]                      rsp_err_q, rsp_err_d;
    logic                            rsp_valid_q, rsp_valid_d;
    logic [2:0]                      a_rail1_q, a_rail1_d, a_rail0_q, a_rail0_d;
    logic [2:0]                      b_rail1_q, b_rail1_d, b_rail0_q, b_rail0_d;
    logic                            mult_ki_q, mult_ki_d, mult_rst_q, mult_rst_d;
    logic                            comp_prev_q, comp_prev_d, nul_prev_q, nul_prev_d;
    logic [SYNC_STAGES-1:0][12:0]    sync_q, sync_d;

    logic [7:0]  valid_pad;
    logic [23:0] a_pad, b_pad;
    logic        found;
    logic [2:0]  gnt_idx, gnt_next;
    logic [3:0]  sum;
    logic [12:0] s_last;
    logic [5:0]  p1_s, p0_s;
    logic        ko_s, comp_now, nul_now, bad, comp_ok, nul_ok, drive_rails;

    assign valid_pad = 8'(req_valid);
    assign a_pad     = 24'(req_a);
    assign b_pad     = 24'(req_b);

    // Every asynchronous multiplier output passes through the same synchronizer chain.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = {mult_ko, p_rail1, p_rail0};
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign s_last      = sync_q[SYNC_STAGES-1];
    assign p0_s        = s_last[5:0];
    assign p1_s        = s_last[11:6];
    assign ko_s        = s_last[12];
    assign comp_now    = (&(p1_s ^ p0_s)) & ~ko_s;
    assign nul_now     = ~(|{p1_s, p0_s}) & ko_s;
    assign bad         = |(p1_s & p0_s);
    assign comp_ok     = comp_now & comp_prev_q;
    assign nul_ok      = nul_now & nul_prev_q;
    assign comp_prev_d = comp_now;
    assign nul_prev_d  = nul_now;

    // Round-robin search: first valid index at or after the pointer, wrapping.
    always_comb begin
        found   = 1'b0;
        gnt_idx = 3'd0;
        sum     = 4'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_q} + 4'(i);
            if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
            if (!found && valid_pad[sum[2:0]]) begin
                found   = 1'b1;
                gnt_idx = sum[2:0];
            end
        end
        gnt_next = (gnt_idx == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = 1'b0;
        ptr_d      = ptr_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        cnt_d      = cnt_q;
        rsp_id_d   = rsp_id_q;
        rsp_prod_d = rsp_prod_q;
        rsp_err_d  = rsp_err_q;
        req_ready  = '0;
        case (state_q)
            S_RST_HOLD: begin
                hold_d = 1'b1;
                if (hold_q) begin
                    hold_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (found) begin
                    req_ready = NUM_REQ'(8'd1 << gnt_idx);
                    op_a_d    = a_pad[5'(gnt_idx) * 5'd3 +: 3];
                    op_b_d    = b_pad[5'(gnt_idx) * 5'd3 +: 3];
                    rsp_id_d  = gnt_idx;
                    ptr_d     = gnt_next;
                    state_d   = S_DRIVE;
                end
            end
            S_DRIVE: begin
                cnt_d   = '0;
                state_d = S_DATA_WAIT;
            end
            S_DATA_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (bad) begin
                    rsp_err_d  = 2'b01;
                    rsp_prod_d = 6'd0;
                    state_d    = S_NULLING;
                end else if (comp_ok) begin
                    rsp_err_d  = 2'b00;
                    rsp_prod_d = p1_s;
                    state_d    = S_NULLING;
                end else if (cnt_d == CW'(TIMEOUT)) begin
                    state_d = S_RECOVER;
                end
            end
            S_NULLING: begin
                cnt_d   = '0;
                state_d = S_NULL_WAIT;
            end
            S_NULL_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (nul_ok) begin
                    state_d = S_RESP;
                end else if (cnt_d == CW'(TIMEOUT)) begin
                    state_d = S_RECOVER;
                end
            end
            S_RECOVER: begin
                hold_d = 1'b1;
                if (hold_q) begin
                    hold_d     = 1'b0;
                    rsp_err_d  = 2'b10;
                    rsp_prod_d = 6'd0;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_RST_HOLD;
        endcase

        // Multiplier-facing outputs are registered from the next state so they never glitch.
        drive_rails = (state_d == S_DRIVE) || (state_d == S_DATA_WAIT);
        a_rail1_d   = drive_rails ? op_a_d  : 3'd0;
        a_rail0_d   = drive_rails ? ~op_a_d : 3'd0;
        b_rail1_d   = drive_rails ? op_b_d  : 3'd0;
        b_rail0_d   = drive_rails ? ~op_b_d : 3'd0;
        mult_ki_d   = !((state_d == S_NULLING) || (state_d == S_NULL_WAIT));
        mult_rst_d  = (state_d == S_RST_HOLD) || (state_d == S_RECOVER);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RST_HOLD;
            hold_q      <= 1'b0;
            ptr_q       <= 3'd0;
            op_a_q      <= 3'd0;
            op_b_q      <= 3'd0;
            cnt_q       <= '0;
            rsp_id_q    <= 3'd0;
            rsp_prod_q  <= 6'd0;
            rsp_err_q   <= 2'b00;
            rsp_valid_q <= 1'b0;
            a_rail1_q   <= 3'd0;
            a_rail0_q   <= 3'd0;
            b_rail1_q   <= 3'd0;
            b_rail0_q   <= 3'd0;
            mult_ki_q   <= 1'b1;
            mult_rst_q  <= 1'b1;
            comp_prev_q <= 1'b0;
            nul_prev_q  <= 1'b0;
            sync_q      <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            ptr_q       <= ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            cnt_q       <= cnt_d;
            rsp_id_q    <= rsp_id_d;
            rsp_prod_q  <= rsp_prod_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            a_rail1_q   <= a_rail1_d;
            a_rail0_q   <= a_rail0_d;
            b_rail1_q   <= b_rail1_d;
            b_rail0_q   <= b_rail0_d;
            mult_ki_q   <= mult_ki_d;
            mult_rst_q  <= mult_rst_d;
            comp_prev_q <= comp_prev_d;
            nul_prev_q  <= nul_prev_d;
            sync_q      <= sync_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_prod  = rsp_prod_q;
    assign rsp_err   = rsp_err_q;
    assign a_rail1   = a_rail1_q;
    assign a_rail0   = a_rail0_q;
    assign b_rail1   = b_rail1_q;
    assign b_rail0   = b_rail0_q;
    assign mult_ki   = mult_ki_q;
    assign mult_rst  = mult_rst_q;

endmodule

// File: tb/tb_ncl_mult3_seq_arbiter.sv
// Bench for ncl_mult3_seq_arbiter: a behavioural NCL multiplier model plus a response
// scoreboard keyed on accepted requests.
module tb_ncl_mult3_seq_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int TIMEOUT     = 16;
    localparam int SYNC_STAGES = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [3*NUM_REQ-1:0] req_a = '0;
    logic [3*NUM_REQ-1:0] req_b = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [2:0]           rsp_id;
    logic [5:0]           rsp_prod;
    logic [1:0]           rsp_err;
    logic [2:0]           a_rail1, a_rail0, b_rail1, b_rail0;
    logic                 mult_ki, mult_rst;
    logic [5:0]           p_rail1 = '0;
    logic [5:0]           p_rail0 = '0;
    logic                 mult_ko = 1'b1;

    ncl_mult3_seq_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_prod(rsp_prod), .rsp_err(rsp_err),
        .a_rail1(a_rail1), .a_rail0(a_rail0), .b_rail1(b_rail1), .b_rail0(b_rail0),
        .mult_ki(mult_ki), .mult_rst(mult_rst), .p_rail1(p_rail1), .p_rail0(p_rail0),
        .mult_ko(mult_ko)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];   // {id, err, prod}
    logic [10:0] got_q[$];
    logic [2:0]  grant_q[$];
    logic [NUM_REQ-1:0] keep_valid = '0;
    int model_mode = 0;      // 0 normal, 1 bit 3 both rails, 2 never completes, 3 never nulls
    int cyc = 0;
    int rst_cnt = 0;
    int first_rst_cyc = 0;
    int grant_cyc = 0;
    bit ki_low_seen, rsp_seen, ready_seen;

    // Behavioural multiplier: a few cycles after a complete DATA input with Ki=1 it presents
    // the product; after a NULL input with Ki=0 it returns to NULL.
    logic [5:0] m_prod;
    int dly_cnt = 0;
    int dly_tgt = 0;
    always @(negedge clk) begin
        m_prod = 6'({3'b000, a_rail1} * {3'b000, b_rail1});
        if (mult_rst) begin
            p_rail1 = '0;
            p_rail0 = '0;
            mult_ko = 1'b1;
            dly_cnt = 0;
        end else if (mult_ko && mult_ki && (&(a_rail1 ^ a_rail0)) && (&(b_rail1 ^ b_rail0))
                     && model_mode != 2) begin
            if (dly_cnt >= dly_tgt) begin
                p_rail1 = m_prod;
                p_rail0 = ~m_prod;
                if (model_mode == 1) begin
                    p_rail1[3] = 1'b1;
                    p_rail0[3] = 1'b1;
                end
                mult_ko = 1'b0;
                dly_cnt = 0;
                dly_tgt = $urandom_range(0, 3);
            end else begin
                dly_cnt++;
            end
        end else if (!mult_ko && !mult_ki && !(|{a_rail1, a_rail0, b_rail1, b_rail0})
                     && model_mode != 3) begin
            if (dly_cnt >= dly_tgt) begin
                p_rail1 = '0;
                p_rail0 = '0;
                mult_ko = 1'b1;
                dly_cnt = 0;
                dly_tgt = $urandom_range(0, 3);
            end else begin
                dly_cnt++;
            end
        end else begin
            dly_cnt = 0;
        end
    end

    // One clock: sample at negedge, record grants/responses, step inputs after the edge.
    task automatic tick();
        logic [NUM_REQ-1:0] hs;
        logic [2:0] a, b;
        int g;
        @(negedge clk);
        hs = req_valid & req_ready;
        g = -1;
        for (int i = 0; i < NUM_REQ; i++) if (hs[i]) g = i;
        if (req_ready != '0) ready_seen = 1'b1;
        if (!mult_ki) ki_low_seen = 1'b1;
        if (rsp_valid) rsp_seen = 1'b1;
        if (mult_rst) begin
            if (rst_cnt == 0) first_rst_cyc = cyc;
            rst_cnt++;
        end
        if (g >= 0) begin
            grant_q.push_back(3'(g));
            a = req_a[3*g +: 3];
            b = req_b[3*g +: 3];
            case (model_mode)
                1:       exp_q.push_back({3'(g), 2'b01, 6'd0});
                2:       exp_q.push_back({3'(g), 2'b10, 6'd0});
                default: exp_q.push_back({3'(g), 2'b00, 6'(a * b)});
            endcase
        end
        if (rsp_valid && rsp_ready) got_q.push_back({rsp_id, rsp_err, rsp_prod});
        @(posedge clk);
        cyc++;
        if (g >= 0) grant_cyc = cyc;
        #1;
        if (g >= 0 && !keep_valid[g]) req_valid[g] = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (got_q.size() < n) begin
            errors++;
            $display("FAIL wait_rsp: got %0d responses, need %0d", got_q.size(), n);
        end
    endtask

    // Error responses carry no meaningful product, so only id and err are compared there.
    function automatic bit rsp_ok(input logic [10:0] g, input logic [10:0] e);
        if (e[7:6] == 2'b01) return g[10:6] === e[10:6];
        return g === e;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        keep_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        got_q.delete();
        grant_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_rail1, a_rail0, b_rail1, b_rail0} !== 12'd0) begin
            errors++; $display("FAIL reset_rails: got %h need 000", {a_rail1, a_rail0, b_rail1, b_rail0});
        end
        checks++;
        if ({mult_ki, mult_rst} !== 2'b11) begin
            errors++; $display("FAIL reset_ki_rst: got %b need 11", {mult_ki, mult_rst});
        end
        checks++;
        if (req_ready !== '0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_ready_valid: got %b/%b need 0/0", req_ready, rsp_valid);
        end
        checks++;
        if ({rsp_id, rsp_err, rsp_prod} !== 11'd0) begin
            errors++; $display("FAIL reset_rsp: got %h need 000", {rsp_id, rsp_err, rsp_prod});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0;
        rst_cnt = 0;
        repeat (5) tick();
        checks++;
        if (rst_cnt != 2) begin
            errors++; $display("FAIL reset_hold: mult_rst high %0d cycles, need 2", rst_cnt);
        end
    endtask

    task automatic test_single();
        logic [10:0] g, e;
        model_mode = 0;
        req_a[8:6] = 3'd5;
        req_b[8:6] = 3'd6;
        req_valid[2] = 1'b1;
        ki_low_seen = 1'b0;
        grant_q.delete();
        for (int n = 0; n < 50 && grant_q.size() == 0; n++) tick();
        checks++;
        if (grant_q.size() == 0) begin
            errors++; $display("FAIL single_grant: no grant, need req 2");
        end
        checks++;
        if ({a_rail1, a_rail0, b_rail1, b_rail0} !== {3'b101, 3'b010, 3'b110, 3'b001}) begin
            errors++; $display("FAIL single_rails: got %b %b %b %b need 101 010 110 001",
                               a_rail1, a_rail0, b_rail1, b_rail0);
        end
        wait_rsp(1, 200);
        checks++;
        if (grant_q.size() != 1 || grant_q[0] !== 3'd2) begin
            errors++; $display("FAIL single_ready: %0d grants, need one to req 2", grant_q.size());
        end
        checks++;
        if (ki_low_seen !== 1'b1 || mult_ki !== 1'b1) begin
            errors++; $display("FAIL single_ki: low_seen=%b now=%b need 1/1", ki_low_seen, mult_ki);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (!rsp_ok(g, e)) begin errors++; $display("FAIL single_rsp: got %h need %h", g, e); end
        end
    endtask

    task automatic test_fairness();
        logic [2:0] order[9];
        logic [10:0] g, e;
        order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd2, 3'd3, 3'd0, 3'd2};
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[3*i +: 3] = 3'(i + 1);
            req_b[3*i +: 3] = 3'(i + 4);
        end
        keep_valid = '1;
        req_valid = '1;
        for (int n = 0; n < 3000 && grant_q.size() < 9; n++) begin
            tick();
            if (grant_q.size() == 5 && keep_valid[1]) begin
                keep_valid[1] = 1'b0;
                req_valid[1] = 1'b0;
            end
        end
        req_valid = '0;
        keep_valid = '0;
        wait_rsp(9, 1000);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (i >= grant_q.size() || grant_q[i] !== order[i]) begin
                errors++; $display("FAIL fair_order[%0d]: got %0d need %0d", i,
                                   (i < grant_q.size()) ? grant_q[i] : 3'd7, order[i]);
            end
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (!rsp_ok(g, e)) begin errors++; $display("FAIL fair_rsp: got %h need %h", g, e); end
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] g, e;
        rsp_ready = 1'b0;
        req_a[2:0] = 3'd7;
        req_b[2:0] = 3'd7;
        req_a[5:3] = 3'd2;
        req_b[5:3] = 3'd2;
        req_valid[0] = 1'b1;
        for (int n = 0; n < 200 && rsp_valid !== 1'b1; n++) tick();
        req_valid[1] = 1'b1;
        keep_valid[1] = 1'b1;
        ready_seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_prod !== 6'd49 || rsp_id !== 3'd0) begin
                errors++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d prod=%0d need v=1 id=0 prod=49",
                                   n, rsp_valid, rsp_id, rsp_prod);
            end
        end
        checks++;
        if (ready_seen !== 1'b0 || got_q.size() != 0) begin
            errors++; $display("FAIL bp_stall: ready_seen=%b rsps=%0d need 0/0", ready_seen, got_q.size());
        end
        rsp_ready = 1'b1;
        req_valid[1] = 1'b0;
        keep_valid[1] = 1'b0;
        repeat (3) tick();
        checks++;
        if (got_q.size() != 1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: rsps=%0d valid=%b need 1/0", got_q.size(), rsp_valid);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (!rsp_ok(g, e)) begin errors++; $display("FAIL bp_rsp: got %h need %h", g, e); end
        end
    endtask

    task automatic test_illegal();
        logic [10:0] g, e;
        model_mode = 1;
        req_a[5:3] = 3'd3;
        req_b[5:3] = 3'd5;
        req_valid[1] = 1'b1;
        ki_low_seen = 1'b0;
        rst_cnt = 0;
        wait_rsp(1, 300);
        model_mode = 0;
        checks++;
        if (ki_low_seen !== 1'b1 || rst_cnt != 0 || mult_ki !== 1'b1) begin
            errors++; $display("FAIL illegal_null: ki_low=%b rst_cycles=%0d ki=%b need 1/0/1",
                               ki_low_seen, rst_cnt, mult_ki);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (!rsp_ok(g, e)) begin errors++; $display("FAIL illegal_rsp: got %h need %h", g, e); end
        end
    endtask

    task automatic test_timeout();
        logic [10:0] g, e;
        model_mode = 2;
        req_a[11:9] = 3'd4;
        req_b[11:9] = 3'd4;
        req_valid[3] = 1'b1;
        rst_cnt = 0;
        wait_rsp(1, 300);
        model_mode = 0;
        checks++;
        if (rst_cnt != 2) begin
            errors++; $display("FAIL timeout_rst_len: mult_rst high %0d cycles, need 2", rst_cnt);
        end
        checks++;
        if (first_rst_cyc - grant_cyc != 17) begin
            errors++; $display("FAIL timeout_rst_start: %0d cycles after grant, need 17",
                               first_rst_cyc - grant_cyc);
        end
        req_a[2:0] = 3'd3;
        req_b[2:0] = 3'd3;
        req_valid[0] = 1'b1;
        wait_rsp(2, 300);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (!rsp_ok(g, e)) begin errors++; $display("FAIL timeout_rsp: got %h need %h", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] g, e;
        int low_run = 0;
        model_mode = 3;
        req_a[8:6] = 3'd2;
        req_b[8:6] = 3'd3;
        req_valid[2] = 1'b1;
        for (int n = 0; n < 200 && low_run < 3; n++) begin
            tick();
            low_run = mult_ki ? 0 : low_run + 1;
        end
        checks++;
        if (low_run < 3) begin
            errors++; $display("FAIL mid_reach_null_wait: ki low run %0d, need 3", low_run);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({a_rail1, a_rail0, b_rail1, b_rail0} !== 12'd0 || mult_ki !== 1'b1 || mult_rst !== 1'b1) begin
            errors++; $display("FAIL mid_reset_state: rails=%h ki=%b rst=%b need 000/1/1",
                               {a_rail1, a_rail0, b_rail1, b_rail0}, mult_ki, mult_rst);
        end
        exp_q.delete();
        model_mode = 0;
        rst_cnt = 0;
        rsp_seen = 1'b0;
        repeat (20) tick();
        checks++;
        if (rst_cnt != 2 || rsp_seen !== 1'b0 || got_q.size() != 0) begin
            errors++; $display("FAIL mid_abort: rst_cycles=%0d rsp_seen=%b rsps=%0d need 2/0/0",
                               rst_cnt, rsp_seen, got_q.size());
        end
        grant_q.delete();
        req_a[5:3] = 3'd2;  req_b[5:3] = 3'd2;
        req_a[11:9] = 3'd6; req_b[11:9] = 3'd5;
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        wait_rsp(2, 400);
        checks++;
        if (grant_q.size() < 1 || grant_q[0] !== 3'd1) begin
            errors++; $display("FAIL mid_pointer: first grant %0d, need 1",
                               (grant_q.size() > 0) ? grant_q[0] : 3'd7);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (!rsp_ok(g, e)) begin errors++; $display("FAIL mid_rsp: got %h need %h", g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_illegal();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
